// File: rtl/regfile_pkg.sv
// Shared register-file widths and the pending-write entry type used by the writeback queue.
package regfile_pkg;

  localparam int ADDR_W   = 4;
  localparam int DATA_W   = 32;
  localparam int NUM_REGS = 16;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_youngest_match.sv
// Scans occupied queue entries for a read address; reports a hit and, with WB_FORWARD_EN,
// the data of the youngest matching entry (zero when no hit).
module wb_youngest_match #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 4
`ifdef WB_FORWARD_EN
  , parameter int DATA_W = 32
`endif
) (
  input  logic [ADDR_W-1:0]         addr_i [DEPTH],
`ifdef WB_FORWARD_EN
  input  logic [DATA_W-1:0]         data_i [DEPTH],
  output logic [DATA_W-1:0]         data_o,
`endif
  input  logic [DEPTH-1:0]          valid_i,
  input  logic [$clog2(DEPTH)-1:0]  head_i,
  input  logic [ADDR_W-1:0]         rd_addr_i,
  output logic                      hit_o
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0] idx;

  // Walk from oldest (head) to youngest so a later match overrides an earlier one.
  always_comb begin
    hit_o = 1'b0;
    idx   = '0;
`ifdef WB_FORWARD_EN
    data_o = '0;
`endif
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_i + PTR_W'(i);
      if (valid_i[idx] && (addr_i[idx] == rd_addr_i)) begin
        hit_o = 1'b1;
`ifdef WB_FORWARD_EN
        data_o = data_i[idx];
`endif
      end
    end
  end

endmodule

// File: rtl/writeback_queue.sv
// FIFO of pending register-file writes drained whenever the write port is free; flags reads
// that target a queued address. Define WB_FORWARD_EN to add youngest-match data forwarding.
module writeback_queue #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = regfile_pkg::ADDR_W,
  parameter int DATA_W = regfile_pkg::DATA_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [ADDR_W-1:0]        in_addr,
  input  logic [DATA_W-1:0]        in_data,
  input  logic                     rf_hold,
  output logic                     rf_we,
  output logic [ADDR_W-1:0]        rf_a3,
  output logic [DATA_W-1:0]        rf_wd3,
  input  logic [ADDR_W-1:0]        rd_a1,
  input  logic [ADDR_W-1:0]        rd_a2,
  output logic                     hit1,
  output logic                     hit2,
`ifdef WB_FORWARD_EN
  output logic [DATA_W-1:0]        fwd_data1,
  output logic [DATA_W-1:0]        fwd_data2,
`endif
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } slot_t;

  slot_t            mem_q [DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push, pop, empty;
  logic [DEPTH-1:0] valid;
  logic [ADDR_W-1:0] addr_arr [DEPTH];
`ifdef WB_FORWARD_EN
  logic [DATA_W-1:0] data_arr [DEPTH];
`endif

  // Control outputs depend only on pointers/count, never on stored data.
  assign empty    = (count_q == '0);
  assign in_ready = (count_q != CNT_W'(DEPTH));
  assign push     = in_valid && in_ready;
  assign rf_we    = !empty && !rf_hold;
  assign pop      = rf_we;
  assign rf_a3    = empty ? '0 : mem_q[head_q].addr;
  assign rf_wd3   = empty ? '0 : mem_q[head_q].data;
  assign count    = count_q;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (push) tail_d = tail_q + 1'b1;
    if (pop)  head_d = head_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Slot k is occupied when its distance from head is below the occupancy.
  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      valid[k]    = ({1'b0, PTR_W'(k) - head_q} < count_q);
      addr_arr[k] = mem_q[k].addr;
`ifdef WB_FORWARD_EN
      data_arr[k] = mem_q[k].data;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[tail_q].addr <= in_addr;
      mem_q[tail_q].data <= in_data;
    end
  end

  wb_youngest_match #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
`ifdef WB_FORWARD_EN
    , .DATA_W (DATA_W)
`endif
  ) u_match1 (
    .addr_i    (addr_arr),
`ifdef WB_FORWARD_EN
    .data_i    (data_arr),
    .data_o    (fwd_data1),
`endif
    .valid_i   (valid),
    .head_i    (head_q),
    .rd_addr_i (rd_a1),
    .hit_o     (hit1)
  );

  wb_youngest_match #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
`ifdef WB_FORWARD_EN
    , .DATA_W (DATA_W)
`endif
  ) u_match2 (
    .addr_i    (addr_arr),
`ifdef WB_FORWARD_EN
    .data_i    (data_arr),
    .data_o    (fwd_data2),
`endif
    .valid_i   (valid),
    .head_i    (head_q),
    .rd_addr_i (rd_a2),
    .hit_o     (hit2)
  );

endmodule

// File: tb/tb_writeback_queue.sv
// Directed bench for writeback_queue: reset, latency, hold/backpressure, refill, hits, mid-run reset.
module tb_writeback_queue;

  localparam int DEPTH  = 4;
  localparam int ADDR_W = 4;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [ADDR_W-1:0] in_addr;
  logic [DATA_W-1:0] in_data;
  logic              rf_hold;
  logic              rf_we;
  logic [ADDR_W-1:0] rf_a3;
  logic [DATA_W-1:0] rf_wd3;
  logic [ADDR_W-1:0] rd_a1, rd_a2;
  logic              hit1, hit2;
`ifdef WB_FORWARD_EN
  logic [DATA_W-1:0] fwd_data1, fwd_data2;
`endif
  logic [2:0]        count;

  int passed = 0;
  int failed = 0;
  int total  = 0;
  int wr_cnt = 0;
  int wr_snap;

  always #5 clk = ~clk;

  always @(posedge clk) if (rf_we === 1'b1) wr_cnt <= wr_cnt + 1;

  writeback_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_addr   (in_addr),
    .in_data   (in_data),
    .rf_hold   (rf_hold),
    .rf_we     (rf_we),
    .rf_a3     (rf_a3),
    .rf_wd3    (rf_wd3),
    .rd_a1     (rd_a1),
    .rd_a2     (rd_a2),
    .hit1      (hit1),
    .hit2      (hit2),
`ifdef WB_FORWARD_EN
    .fwd_data1 (fwd_data1),
    .fwd_data2 (fwd_data2),
`endif
    .count     (count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [ADDR_W-1:0] exp_a [3];
    logic [DATA_W-1:0] exp_d [3];

    rst_n = 1'b0; in_valid = 1'b0; in_addr = '0; in_data = '0;
    rf_hold = 1'b0; rd_a1 = '0; rd_a2 = '0;
    #2;
    chk("rst_count", 32'(count), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_rf_we", 32'(rf_we), 0);
    chk("rst_rf_a3", 32'(rf_a3), 0);
    chk("rst_rf_wd3", rf_wd3, 0);
    chk("rst_hit1", 32'(hit1), 0);
    chk("rst_hit2", 32'(hit2), 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Single push: no bypass, written one cycle later.
    in_valid = 1'b1; in_addr = 4'd3; in_data = 32'hABCDE123;
    #1;
    chk("nobypass_rf_we", 32'(rf_we), 0);
    tick();
    in_valid = 1'b0; in_data = 'x;
    #1;
    chk("single_rf_we", 32'(rf_we), 1);
    chk("single_rf_a3", 32'(rf_a3), 3);
    chk("single_rf_wd3", rf_wd3, 32'hABCDE123);
    chk("single_count1", 32'(count), 1);
    tick();
    chk("single_count0", 32'(count), 0);
    chk("single_we_after", 32'(rf_we), 0);

    // Hold with DEPTH+1 push attempts, then drain in order.
    rf_hold = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_addr = 4'(i + 1); in_data = 32'h100 + 32'(i);
      #1;
      chk("hold_in_ready", 32'(in_ready), (i < 4) ? 32'd1 : 32'd0);
      tick();
    end
    in_valid = 1'b0;
    #1;
    chk("hold_count", 32'(count), 4);
    chk("hold_in_ready_full", 32'(in_ready), 0);
    chk("hold_rf_we", 32'(rf_we), 0);
    chk("hold_head_a3", 32'(rf_a3), 1);
    rf_hold = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("drain_rf_we", 32'(rf_we), 1);
      chk("drain_rf_a3", 32'(rf_a3), 32'(i + 1));
      chk("drain_rf_wd3", rf_wd3, 32'h100 + 32'(i));
      tick();
    end
    chk("drain_count", 32'(count), 0);

    // Full queue refused even while popping, then refill.
    rf_hold = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_addr = 4'(8 + i); in_data = 32'h200 + 32'(i);
      tick();
    end
    rf_hold = 1'b0; in_valid = 1'b1; in_addr = 4'd12; in_data = 32'h300;
    #1;
    chk("full_in_ready", 32'(in_ready), 0);
    chk("full_count", 32'(count), 4);
    chk("full_rf_we", 32'(rf_we), 1);
    chk("full_rf_a3", 32'(rf_a3), 8);
    tick();
    chk("refill_count3", 32'(count), 3);
    chk("refill_in_ready", 32'(in_ready), 1);
    rf_hold = 1'b1;
    tick();
    in_valid = 1'b0;
    #1;
    chk("refill_count4", 32'(count), 4);
    rf_hold = 1'b0;
    chk("refill_head_a3", 32'(rf_a3), 9);
    tick();
    chk("pp_count_before", 32'(count), 3);
    in_valid = 1'b1; in_addr = 4'd13; in_data = 32'h400;
    #1;
    chk("pp_rf_a3", 32'(rf_a3), 10);
    chk("pp_rf_wd3", rf_wd3, 32'h202);
    tick();
    in_valid = 1'b0;
    chk("pp_count_after", 32'(count), 3);
    exp_a[0] = 4'd11; exp_a[1] = 4'd12; exp_a[2] = 4'd13;
    exp_d[0] = 32'h203; exp_d[1] = 32'h300; exp_d[2] = 32'h400;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("order_rf_a3", 32'(rf_a3), 32'(exp_a[i]));
      chk("order_rf_wd3", rf_wd3, exp_d[i]);
      tick();
    end
    chk("order_count", 32'(count), 0);

    // Same-address entries: hit and youngest forward.
    rd_a1 = 4'd5; rd_a2 = 4'd6;
    #1;
    chk("hit_empty", 32'(hit1), 0);
    rf_hold = 1'b1;
    in_valid = 1'b1; in_addr = 4'd5; in_data = 32'h11;
    tick();
    in_data = 32'h22;
    tick();
    in_valid = 1'b0;
    #1;
    chk("hit_count", 32'(count), 2);
    chk("hit1_set", 32'(hit1), 1);
    chk("hit2_clr", 32'(hit2), 0);
`ifdef WB_FORWARD_EN
    chk("fwd1_youngest", fwd_data1, 32'h22);
    chk("fwd2_zero", fwd_data2, 32'h0);
`endif
    rf_hold = 1'b0;
    tick();
    chk("hit1_after_pop", 32'(hit1), 1);
`ifdef WB_FORWARD_EN
    chk("fwd1_after_pop", fwd_data1, 32'h22);
`endif
    tick();
    chk("hit1_drained", 32'(hit1), 0);
    chk("hit_drained_count", 32'(count), 0);

    // Reset mid-operation discards three pending entries.
    rf_hold = 1'b1; rd_a1 = 4'd1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_addr = 4'(i + 1); in_data = 32'h501 + 32'(i);
      tick();
    end
    in_valid = 1'b0;
    #1;
    chk("pre_rst_count", 32'(count), 3);
    chk("pre_rst_hit1", 32'(hit1), 1);
    wr_snap = wr_cnt;
    #2;
    rf_hold = 1'b0; rst_n = 1'b0;
    #1;
    chk("mid_rst_rf_we", 32'(rf_we), 0);
    chk("mid_rst_count", 32'(count), 0);
    chk("mid_rst_in_ready", 32'(in_ready), 1);
    chk("mid_rst_hit1", 32'(hit1), 0);
    tick();
    chk("mid_rst_we_held", 32'(rf_we), 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("post_rst_count", 32'(count), 0);
    chk("post_rst_rf_we", 32'(rf_we), 0);
    chk("post_rst_no_write", 32'(wr_cnt), 32'(wr_snap));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
